// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared counter encoding, saturating update and defaults
package branch_predictor_pkg;
  localparam int BP_ENTRIES_DEFAULT = 64;
  typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_t;
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    return taken ? ((ctr == ST) ? ST : bp_ctr_t'(ctr + 2'd1))
                 : ((ctr == SNT) ? SNT : bp_ctr_t'(ctr - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and execute training signals
interface branch_predictor_if;
  logic [31:0] PC_F;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  logic        Branch_E;
  logic        Jump_E;
  logic        Branch_Taken_E;
  logic [31:0] PC_E;
  logic [31:0] Branch_Target_E;
  modport master (
    output PC_F, Branch_E, Jump_E, Branch_Taken_E, PC_E, Branch_Target_E,
    input  Predict_Taken_F, Predict_Target_F
  );
  modport slave (
    input  PC_F, Branch_E, Jump_E, Branch_Taken_E, PC_E, Branch_Target_E,
    output Predict_Taken_F, Predict_Target_F
  );
endinterface

// File: rtl/branch_predictor_bp_counter_update.sv
// bp_counter_update: combinational 2-bit saturating counter next state
module bp_counter_update
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);
  assign ctr_next = bp_ctr_next(ctr, taken);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES_DEFAULT
) (
  input logic CLK,
  input logic RST,
  branch_predictor_if.slave bp
);
  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  if (ENTRIES < 4 || (1 << INDEX_BITS) != ENTRIES) begin : g_bad_entries
    $error("ENTRIES must be a power of two and at least 4");
  end
  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  bp_ctr_t               ctr_q    [ENTRIES];
  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e, taken_f;
  bp_ctr_t               ctr_upd;
  logic                  unused_bits;
  assign unused_bits = ^{bp.PC_F[1:0], bp.PC_E[1:0]};
  assign idx_f = bp.PC_F[INDEX_BITS+1:2];
  assign tag_f = bp.PC_F[31:INDEX_BITS+2];
  assign idx_e = bp.PC_E[INDEX_BITS+1:2];
  assign tag_e = bp.PC_E[31:INDEX_BITS+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign taken_f = !RST && hit_f && ctr_q[idx_f][1];
  assign bp.Predict_Taken_F = taken_f;
  assign bp.Predict_Target_F = taken_f ? target_q[idx_f] : 32'h0;
  bp_counter_update u_ctr (
    .ctr      (ctr_q[idx_e]),
    .taken    (bp.Branch_Taken_E),
    .ctr_next (ctr_upd)
  );
  // Jumps always (re)allocate as strongly taken; branches train only on hit or taken miss
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= WNT;
      end
    end else if (bp.Jump_E) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= bp.Branch_Target_E;
      ctr_q[idx_e]    <= ST;
    end else if (bp.Branch_E) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_upd;
        if (bp.Branch_Taken_E) target_q[idx_e] <= bp.Branch_Target_E;
      end else if (bp.Branch_Taken_E) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= bp.Branch_Target_E;
        ctr_q[idx_e]    <= WT;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for the BTB predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_pass = 0;
  typedef struct {
    string       tag;
    logic [32:0] exp;
  } sb_t;
  sb_t sb_q[$];
  branch_predictor_if bp();
  branch_predictor #(.ENTRIES(64)) dut (
    .CLK (clk),
    .RST (rst),
    .bp  (bp.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
                  tag, got[32], got[31:0], exp[32], exp[31:0]);
  endtask
  task automatic tick(input string tag, input logic r, input logic [31:0] pc_f,
                      input logic br, input logic jp, input logic tk,
                      input logic [31:0] pc_e, input logic [31:0] tgt_e,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    sb_t e;
    @(negedge clk);
    rst = r;
    bp.PC_F = pc_f;
    bp.Branch_E = br;
    bp.Jump_E = jp;
    bp.Branch_Taken_E = tk;
    bp.PC_E = pc_e;
    bp.Branch_Target_E = tgt_e;
    sb_q.push_back('{tag, {exp_tk, exp_tgt}});
    #1;
    e = sb_q.pop_front();
    check(e.tag, {bp.Predict_Taken_F, bp.Predict_Target_F}, e.exp);
  endtask
  initial begin
    rst = 1'b1;
    bp.PC_F = 32'h0;
    bp.Branch_E = 1'b0;
    bp.Jump_E = 1'b0;
    bp.Branch_Taken_E = 1'b0;
    bp.PC_E = 32'h0;
    bp.Branch_Target_E = 32'h0;
    tick("rst_out",      1, 32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    tick("alloc_nobyp",  0, 32'h100, 1, 0, 1, 32'h100, 32'h80,  0, 32'h0);
    tick("alloc_wt",     0, 32'h100, 1, 0, 1, 32'h100, 32'h80,  1, 32'h80);
    tick("inc_st",       0, 32'h100, 1, 0, 1, 32'h100, 32'h80,  1, 32'h80);
    tick("sat_st",       0, 32'h100, 1, 0, 1, 32'h100, 32'h84,  1, 32'h80);
    tick("tgt_overwr",   0, 32'h100, 1, 0, 0, 32'h100, 32'h999, 1, 32'h84);
    tick("dec_wt",       0, 32'h100, 1, 0, 0, 32'h100, 32'h999, 1, 32'h84);
    tick("dec_wnt",      0, 32'h100, 1, 0, 0, 32'h100, 32'h999, 0, 32'h0);
    tick("dec_snt",      0, 32'h100, 1, 0, 0, 32'h100, 32'h999, 0, 32'h0);
    tick("sat_snt",      0, 32'h100, 1, 0, 1, 32'h100, 32'h88,  0, 32'h0);
    tick("inc_wnt",      0, 32'h100, 1, 0, 1, 32'h100, 32'h88,  0, 32'h0);
    tick("inc_wt",       0, 32'h100, 0, 0, 0, 32'h0,   32'h0,   1, 32'h88);
    tick("alias_miss",   0, 32'h200, 1, 0, 1, 32'h200, 32'h300, 0, 32'h0);
    tick("alias_evict",  0, 32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    tick("alias_new",    0, 32'h200, 0, 0, 0, 32'h0,   32'h0,   1, 32'h300);
    tick("nt_miss_pre",  0, 32'h104, 1, 0, 0, 32'h104, 32'h700, 0, 32'h0);
    tick("nt_miss_nowr", 0, 32'h104, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    tick("jump_nobyp",   0, 32'h40,  1, 1, 0, 32'h40,  32'h400, 0, 32'h0);
    tick("jump_alloc",   0, 32'h40,  1, 0, 0, 32'h40,  32'h444, 1, 32'h400);
    tick("jump_was_st",  0, 32'h40,  0, 0, 0, 32'h0,   32'h0,   1, 32'h400);
    tick("retrain",      0, 32'h200, 1, 0, 1, 32'h100, 32'h500, 1, 32'h300);
    tick("retrain_wt",   0, 32'h100, 1, 0, 1, 32'h100, 32'h500, 1, 32'h500);
    tick("rst_force",    1, 32'h100, 1, 0, 1, 32'h104, 32'h600, 0, 32'h0);
    tick("rst_wipe_100", 0, 32'h100, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    tick("rst_drop_104", 0, 32'h104, 0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    tick("rst_wipe_40",  0, 32'h40,  0, 0, 0, 32'h0,   32'h0,   0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB), with one 2-bit saturating counter per entry.
- Looks up PC_F combinationally and drives Predict_Taken_F / Predict_Target_F to the PC-select mux.
- Predict_Taken travels down the pipeline to E, where the hazard control unit compares it with the actual branch outcome.
- Trained from the Execute stage using the resolved branch outcome and target.

Parameters:
- ENTRIES, 64, number of BTB entries; must be a power of two, minimum 4.
- INDEX_BITS, $clog2(ENTRIES), derived; not to be overridden.
- TAG_BITS, 30-INDEX_BITS, derived; upper PC bits stored per entry.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- PC_F  input  32  fetch PC, word aligned.
- Predict_Taken_F  output  1  predicted taken for PC_F.
- Predict_Target_F  output  32  predicted target; 0 when Predict_Taken_F=0.
- Branch_E  input  1  conditional branch valid in E; flushed bubbles drive 0.
- Jump_E  input  1  JAL/JALR valid in E.
- Branch_Taken_E  input  1  resolved outcome; ignored when Jump_E=1, which is treated as taken.
- PC_E  input  32  PC of the instruction in E.
- Branch_Target_E  input  32  resolved target address.

Behaviour:
- One clock, CLK; reset is synchronous and active-high on RST.
- Index = PC[INDEX_BITS+1:2]. Tag = PC[31:INDEX_BITS+2]. PC[1:0] ignored.
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Counter encoding (from package): SNT=00, WNT=01, WT=10, ST=11.
- Lookup is purely combinational, zero latency:
  - hit = valid && tag match.
  - Predict_Taken_F = hit && ctr[1].
  - Predict_Target_F = target when Predict_Taken_F=1, else 32'h0.
- While RST=1, both outputs are forced to 0.
- Reset, at the CLK edge with RST=1:
  - all valid bits cleared, all counters set to WNT, targets set to 0.
  - any update presented in the same cycle is discarded.
  - reset mid-operation wipes all training.
- Update happens at the CLK edge when (Branch_E || Jump_E) && !RST, at the entry indexed by PC_E:
  - Jump_E, hit or miss: valid=1, tag written, target written, ctr=ST.
  - Branch, hit, taken: ctr increments, saturating at ST; target overwritten.
  - Branch, hit, not taken: ctr decrements, saturating at SNT; target unchanged.
  - Branch, miss, taken: allocate (overwriting any conflicting entry); valid=1, tag written, target written, ctr=WT.
  - Branch, miss, not taken: no write.
- Branch_E and Jump_E both high: Jump_E has priority.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents (no bypass). The new value is visible from the next cycle.
- Aliasing: only the tag is compared, so a different PC with the same index is a miss and never uses another PC's counter.
- Stall/flush: the predictor holds no pipeline state. Stalls do not gate updates; correctness relies on flushed E bubbles having Branch_E=Jump_E=0.
- Storage: a register array is acceptable; a read-before-write synchronous RAM is not required.

Decomposition:
- definitions package gains:
  - typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_t.
  - function bp_ctr_next(ctr, taken), the saturating update.
  - constant BP_ENTRIES_DEFAULT = 64.
- One natural sub-module: bp_counter_update, the combinational saturating-counter next-state logic, unit-testable in isolation.
- The table storage and lookup stay in branch_predictor.

Test Plan:
- Reset: RST=1 for 1 cycle, then PC_F=0x100 -> Predict_Taken_F=0, Predict_Target_F=0x0; during RST both outputs are 0.
- Allocation: Branch_E=1, Branch_Taken_E=1, PC_E=0x100, target 0x80 -> next cycle PC_F=0x100 gives taken=1, target=0x80; ctr=WT.
- Saturation: 3 more taken updates at 0x100 -> ctr=ST; then 1 not-taken -> still taken (WT); 2nd not-taken -> not taken (WNT); 3 more -> SNT, and further decrements stay at SNT.
- Alias: ENTRIES=64; after training 0x100, PC_F=0x200 (same index, different tag) -> miss, taken=0. A taken branch at PC_E=0x200 evicts the 0x100 entry, so 0x100 now misses.
- Jump priority and no-bypass:
  - Jump_E=1 and Branch_E=1, Branch_Taken_E=0, PC_E=0x40, target 0x400 -> entry ST, target 0x400.
  - In the update cycle, PC_F=0x40 still reads miss; next cycle it reads taken, target 0x400.
- Reset mid-operation: train 0x100 to ST, assert RST coincident with an update to 0x104 -> afterwards both 0x100 and 0x104 miss.
